// File: rtl/mem_block_arbiter.sv
// Two-requester round-robin arbiter and two-phase (setup/access) bus sequencer for one mem_block bank.
// An access stalled on m_ready for TIMEOUT cycles is aborted and reported to the winner as an err pulse.
module mem_block_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_done,
    output logic                  req0_err,
    output logic [DATA_WIDTH-1:0] req0_rdata,

    input  logic                  req1_valid,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_done,
    output logic                  req1_err,
    output logic [DATA_WIDTH-1:0] req1_rdata,

    output logic                  m_sel,
    output logic                  m_enable,
    output logic                  m_wr,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_ready,
    input  logic [DATA_WIDTH-1:0] m_rdata
);

    // A zero TIMEOUT still needs a legal one-bit counter even though it never counts.
    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e                 state_q,    state_d;
    logic                   last_q,     last_d;
    logic                   gnt_q,      gnt_d;
    logic [CNT_W-1:0]       cnt_q,      cnt_d;
    logic                   m_sel_q,    m_sel_d;
    logic                   m_enable_q, m_enable_d;
    logic                   m_wr_q,     m_wr_d;
    logic [ADDR_WIDTH-1:0]  m_addr_q,   m_addr_d;
    logic [DATA_WIDTH-1:0]  m_wdata_q,  m_wdata_d;
    logic                   done0_q,    done0_d;
    logic                   err0_q,     err0_d;
    logic                   done1_q,    done1_d;
    logic                   err1_q,     err1_d;
    logic [DATA_WIDTH-1:0]  rdata0_q,   rdata0_d;
    logic [DATA_WIDTH-1:0]  rdata1_q,   rdata1_d;

    logic                   win_c;
    logic [CNT_W-1:0]       cnt_inc_c;

    // Next-state, arbitration and bus/response register updates.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        m_sel_d    = m_sel_q;
        m_enable_d = m_enable_q;
        m_wr_d     = m_wr_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        done0_d    = 1'b0;
        err0_d     = 1'b0;
        done1_d    = 1'b0;
        err1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        win_c      = 1'b0;
        cnt_inc_c  = cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie the requester that did not win last time gets the bus.
                    win_c     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
                    gnt_d     = win_c;
                    last_d    = win_c;
                    m_wr_d    = win_c ? req1_wr    : req0_wr;
                    m_addr_d  = win_c ? req1_addr  : req0_addr;
                    m_wdata_d = win_c ? req1_wdata : req0_wdata;
                    m_sel_d   = 1'b1;
                    state_d   = S_SETUP;
                end
            end

            S_SETUP: begin
                m_enable_d = 1'b1;
                cnt_d      = '0;
                state_d    = S_ACCESS;
            end

            S_ACCESS: begin
                if (m_ready) begin
                    state_d    = S_RESP;
                    m_sel_d    = 1'b0;
                    m_enable_d = 1'b0;
                    if (gnt_q) begin
                        done1_d = 1'b1;
                        if (!m_wr_q) rdata1_d = m_rdata;
                    end else begin
                        done0_d = 1'b1;
                        if (!m_wr_q) rdata0_d = m_rdata;
                    end
                end else if ((TIMEOUT != 0) && (cnt_inc_c == CNT_W'(TIMEOUT))) begin
                    // Stalled slave: abort, and a read returns zero rather than stale data.
                    state_d    = S_RESP;
                    m_sel_d    = 1'b0;
                    m_enable_d = 1'b0;
                    if (gnt_q) begin
                        err1_d = 1'b1;
                        if (!m_wr_q) rdata1_d = '0;
                    end else begin
                        err0_d = 1'b1;
                        if (!m_wr_q) rdata0_d = '0;
                    end
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_inc_c;
                end
            end

            S_RESP: begin
                state_d   = S_IDLE;
                m_wr_d    = 1'b0;
                m_addr_d  = '0;
                m_wdata_d = '0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            cnt_q      <= '0;
            m_sel_q    <= 1'b0;
            m_enable_q <= 1'b0;
            m_wr_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            done0_q    <= 1'b0;
            err0_q     <= 1'b0;
            done1_q    <= 1'b0;
            err1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            m_sel_q    <= m_sel_d;
            m_enable_q <= m_enable_d;
            m_wr_q     <= m_wr_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            done0_q    <= done0_d;
            err0_q     <= err0_d;
            done1_q    <= done1_d;
            err1_q     <= err1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign req0_done  = done0_q;
    assign req0_err   = err0_q;
    assign req0_rdata = rdata0_q;
    assign req1_done  = done1_q;
    assign req1_err   = err1_q;
    assign req1_rdata = rdata1_q;
    assign m_sel      = m_sel_q;
    assign m_enable   = m_enable_q;
    assign m_wr       = m_wr_q;
    assign m_addr     = m_addr_q;
    assign m_wdata    = m_wdata_q;

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Scoreboard bench for mem_block_arbiter: directed transfers against a behavioural register-bank slave.
module tb_mem_block_arbiter;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned TO    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_wr, req0_done, req0_err;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, req0_rdata;
    logic          req1_valid, req1_wr, req1_done, req1_err;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, req1_rdata;
    logic          m_sel, m_enable, m_wr, m_ready;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    mem_block_arbiter #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_wr    (req0_wr),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_done  (req0_done),
        .req0_err   (req0_err),
        .req0_rdata (req0_rdata),
        .req1_valid (req1_valid),
        .req1_wr    (req1_wr),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_done  (req1_done),
        .req1_err   (req1_err),
        .req1_rdata (req1_rdata),
        .m_sel      (m_sel),
        .m_enable   (m_enable),
        .m_wr       (m_wr),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_ready    (m_ready),
        .m_rdata    (m_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural slave: combinational read, write on an accepted access cycle.
    logic [DW-1:0] mem [DEPTH];
    logic          ready_en;
    assign m_ready = ready_en;
    assign m_rdata = mem[m_addr];
    always @(posedge clk) begin
        if (m_sel && m_enable && m_ready && m_wr) mem[m_addr] <= m_wdata;
    end

    typedef struct {
        int            id;
        bit            err;
        logic [AW-1:0] addr;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            pulse_cyc[$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            mon_np;
    logic [DW-1:0] mdl_rd0 = '0;
    logic [DW-1:0] mdl_rd1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_exp(input int id, input bit wr, input logic [AW-1:0] addr,
                                     input bit err, input logic [DW-1:0] rdata);
        exp_t e;
        if (!wr) begin
            if (id == 0) mdl_rd0 = err ? '0 : rdata;
            else         mdl_rd1 = err ? '0 : rdata;
        end
        e.id   = id;
        e.err  = err;
        e.addr = addr;
        e.rd0  = mdl_rd0;
        e.rd1  = mdl_rd1;
        sb.push_back(e);
    endfunction

    // Monitor: every done/err pulse is matched against the oldest expected response.
    always @(negedge clk) begin
        if (reset && (req0_done || req0_err || req1_done || req1_err)) begin
            pulse_cyc.push_back(cyc);
            mon_np = int'(req0_done) + int'(req0_err) + int'(req1_done) + int'(req1_err);
            check("single_pulse", 32'(mon_np), 32'd1);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got done/err %b%b%b%b expected none (cycle %0d)",
                         req0_done, req0_err, req1_done, req1_err, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("resp_requester", 32'(req1_done | req1_err), 32'(mon_e.id));
                check("resp_err",       32'(req0_err | req1_err),  32'(mon_e.err));
                check("resp_addr",      32'(m_addr),               32'(mon_e.addr));
                check("resp_rdata0",    32'(req0_rdata),           32'(mon_e.rd0));
                check("resp_rdata1",    32'(req1_rdata),           32'(mon_e.rd1));
                check("resp_bus_idle",  32'({m_sel, m_enable}),    32'd0);
            end
        end
    end

    task automatic drive(input int id, input bit v, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id == 0) begin
            req0_valid = v; req0_wr = wr; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_wr = wr; req1_addr = a; req1_wdata = d;
        end
    endtask

    // Single-requester transfer from IDLE; checks phase timing and access-phase length.
    task automatic do_txn(input int id, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input bit exp_err,
                          input logic [DW-1:0] exp_rdata, input int exp_access);
        int k   = 0;
        int acc = 0;
        bit got = 1'b0;
        push_exp(id, wr, addr, exp_err, exp_rdata);
        @(posedge clk); #1;
        drive(id, 1'b1, wr, addr, wdata);
        while (!got && k < 64) begin
            @(posedge clk); #1;
            k++;
            if (m_enable) acc++;
            if (k == 1) check("setup_phase",  32'({m_sel, m_enable}), 32'b10);
            if (k == 2) check("access_phase", 32'({m_sel, m_enable}), 32'b11);
            got = (id == 0) ? (req0_done | req0_err) : (req1_done | req1_err);
        end
        check("txn_complete",  32'(got), 32'd1);
        check("txn_latency",   32'(k),   32'(2 + exp_access));
        check("access_cycles", 32'(acc), 32'(exp_access));
        drive(id, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_pulses(input int n);
        int seen = 0;
        int k    = 0;
        while (seen < n && k < 64) begin
            @(posedge clk); #1;
            k++;
            if (req0_done || req0_err || req1_done || req1_err) seen++;
        end
        check("pulse_wait", 32'(seen), 32'(n));
    endtask

    task automatic check_gaps(input string name, input int n);
        check({name, "_count"}, 32'(pulse_cyc.size()), 32'(n));
        for (int i = 1; i < pulse_cyc.size(); i++)
            check(name, 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'd4);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        mdl_rd0 = '0;
        mdl_rd1 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[AW'(i)] = '0;
        reset    = 1'b0;
        ready_en = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_bus",  32'({m_sel, m_enable, m_wr, m_addr, m_wdata}), 32'd0);
        check("reset_resp", 32'({req0_done, req0_err, req1_done, req1_err}), 32'd0);
        check("reset_rdata", 32'({req0_rdata, req1_rdata}), 32'd0);
        reset = 1'b1;

        // Write then read back through requester 0.
        do_txn(0, 1'b1, 5'd5, 8'hA5, 1'b0, 8'h00, 1);
        do_txn(0, 1'b0, 5'd5, 8'h00, 1'b0, 8'hA5, 1);

        // Both requesters held valid: grants alternate 0,1,0,1 starting with req0.
        apply_reset();
        push_exp(0, 1'b1, 5'd3, 1'b0, 8'h00);
        push_exp(1, 1'b1, 5'd7, 1'b0, 8'h00);
        push_exp(0, 1'b1, 5'd3, 1'b0, 8'h00);
        push_exp(1, 1'b1, 5'd7, 1'b0, 8'h00);
        pulse_cyc.delete();
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 5'd3, 8'h33);
        drive(1, 1'b1, 1'b1, 5'd7, 8'h77);
        wait_pulses(3);
        drive(0, 1'b0, 1'b0, '0, '0);
        wait_pulses(1);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        check_gaps("rr_pulse_gap", 4);

        // Requester 1 alone, back-to-back reads.
        pulse_cyc.delete();
        do_txn(1, 1'b0, 5'd7, 8'h00, 1'b0, 8'h77, 1);
        do_txn(1, 1'b0, 5'd3, 8'h00, 1'b0, 8'h33, 1);
        do_txn(1, 1'b0, 5'd5, 8'h00, 1'b0, 8'hA5, 1);
        @(posedge clk); #1;
        check_gaps("b2b_pulse_gap", 3);

        // Timeout on a stalled slave zeroes the read data, then normal service resumes.
        do_txn(0, 1'b0, 5'd7, 8'h00, 1'b0, 8'h77, 1);
        ready_en = 1'b0;
        do_txn(0, 1'b0, 5'd5, 8'h00, 1'b1, 8'h00, 4);
        ready_en = 1'b1;
        do_txn(0, 1'b0, 5'd3, 8'h00, 1'b0, 8'h33, 1);

        // Reset during ACCESS drops the transfer; req0 wins first after release.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 5'd5, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_access", 32'({m_sel, m_enable}), 32'b11);
        #2 reset = 1'b0;
        #1;
        check("midreset_bus",  32'({m_sel, m_enable, m_wr, m_addr, m_wdata}), 32'd0);
        check("midreset_resp", 32'({req0_done, req0_err, req1_done, req1_err}), 32'd0);
        check("midreset_rdata", 32'({req0_rdata, req1_rdata}), 32'd0);
        mdl_rd0 = '0;
        mdl_rd1 = '0;
        drive(0, 1'b1, 1'b0, 5'd3, 8'h00);
        drive(1, 1'b1, 1'b0, 5'd5, 8'h00);
        push_exp(0, 1'b0, 5'd3, 1'b0, 8'h33);
        push_exp(1, 1'b0, 5'd5, 1'b0, 8'hA5);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        wait_pulses(1);
        drive(0, 1'b0, 1'b0, '0, '0);
        wait_pulses(1);
        drive(1, 1'b0, 1'b0, '0, '0);

        // Address extremes; req0 read data must hold while req1 reads.
        do_txn(0, 1'b1, 5'd31, 8'hFF, 1'b0, 8'h00, 1);
        do_txn(0, 1'b1, 5'd0,  8'h01, 1'b0, 8'h00, 1);
        do_txn(0, 1'b0, 5'd31, 8'h00, 1'b0, 8'hFF, 1);
        do_txn(0, 1'b0, 5'd0,  8'h00, 1'b0, 8'h01, 1);
        do_txn(1, 1'b0, 5'd31, 8'h00, 1'b0, 8'hFF, 1);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("idle_bus", 32'({m_sel, m_enable, m_wr, m_addr, m_wdata}), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
